// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA request arbiter: HRQ/HLDA handshake, fixed or rotating priority.
// Define DMA_DREQ_SYNC_EN to pass DREQ through a 2-flop synchronizer (HRQ latency 3 cycles).
module dma_channel_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskReg,
  input  logic       priorityType,
  input  logic       HLDA,
  input  logic       transferDone,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       grantValid,
  output logic [1:0] grantChannel,
  output logic [7:0] priorityOrder
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE} state_t;
  localparam logic [7:0] ORDER_RST = 8'b11_10_01_00;

  state_t     state_q;
  logic       hrq_q;
  logic [3:0] dack_q;
  logic       gv_q;
  logic [1:0] gch_q;
  logic [7:0] order_q;
  logic [3:0] dreq_s;
  logic [3:0] eff_req;
  logic [1:0] win_ch;
  logic [7:0] rot_order;

`ifdef DMA_DREQ_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= DREQ;
      sync2_q <= sync1_q;
    end
  end
  assign dreq_s = sync2_q;
`else
  assign dreq_s = DREQ;
`endif

  assign eff_req = dreq_s & ~maskReg;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    win_ch = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (eff_req[order_q[2*i +: 2]]) win_ch = order_q[2*i +: 2];
    end
  end

  // Served channel drops to the bottom; the rest slide up keeping relative order.
  always_comb begin
    int k;
    k = 0;
    rot_order = order_q;
    for (int i = 0; i < 4; i++) begin
      if (order_q[2*i +: 2] != gch_q) begin
        rot_order[2*k +: 2] = order_q[2*i +: 2];
        k = k + 1;
      end
    end
    rot_order[7:6] = gch_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      hrq_q   <= 1'b0;
      dack_q  <= 4'b0000;
      gv_q    <= 1'b0;
      gch_q   <= 2'b00;
      order_q <= ORDER_RST;
    end else begin
      if (!priorityType) order_q <= ORDER_RST;
      case (state_q)
        S_IDLE: begin
          if (|eff_req) begin
            state_q <= S_REQ;
            hrq_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (HLDA) begin
            if (|eff_req) begin
              state_q <= S_GRANT;
              dack_q  <= 4'b0001 << win_ch;
              gv_q    <= 1'b1;
              gch_q   <= win_ch;
            end else begin
              state_q <= S_RELEASE;
              hrq_q   <= 1'b0;
            end
          end else if (!(|eff_req)) begin
            state_q <= S_IDLE;
            hrq_q   <= 1'b0;
          end
        end
        S_GRANT: begin
          // Losing HLDA aborts without touching the priority order.
          if (!HLDA || transferDone) begin
            state_q <= HLDA ? S_RELEASE : S_IDLE;
            hrq_q   <= 1'b0;
            dack_q  <= 4'b0000;
            gv_q    <= 1'b0;
            gch_q   <= 2'b00;
            if (HLDA && priorityType) order_q <= rot_order;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
          hrq_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          hrq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign grantValid    = gv_q;
  assign grantChannel  = gch_q;
  assign priorityOrder = order_q;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboarded bench for dma_channel_arbiter (default build, no DREQ synchronizer).
module tb_dma_channel_arbiter;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = '0;
  logic [3:0] maskReg = '0;
  logic       priorityType = 1'b0;
  logic       HLDA = 1'b0;
  logic       transferDone = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [7:0] priorityOrder;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [5:0] exp_q[$];
  logic [3:0] prev_dack = '0;
  logic [5:0] exp_grant;

  dma_channel_arbiter dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
    .priorityType(priorityType), .HLDA(HLDA), .transferDone(transferDone),
    .HRQ(HRQ), .DACK(DACK), .grantValid(grantValid),
    .grantChannel(grantChannel), .priorityOrder(priorityOrder)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_grant(input logic [3:0] dack, input logic [1:0] ch);
    exp_q.push_back({dack, ch});
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (DACK == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_wait", {31'd0, DACK != 4'b0000}, 32'd1);
  endtask

  task automatic pulse_done();
    transferDone = 1'b1;
    tick();
    transferDone = 1'b0;
    chk("done_hrq", {31'd0, HRQ}, 32'd0);
    chk("done_dack", {28'd0, DACK}, 32'd0);
    chk("done_gch", {30'd0, grantChannel}, 32'd0);
  endtask

  // Grant monitor: every rising DACK consumes one scoreboard entry.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      chk("gv_inv", {31'd0, grantValid}, {31'd0, DACK != 4'b0000});
      if (DACK != 4'b0000 && prev_dack == 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {28'd0, DACK}, 32'd0);
        end else begin
          exp_grant = exp_q.pop_front();
          chk("sb_grant", {26'd0, DACK, grantChannel}, {26'd0, exp_grant});
        end
      end
      prev_dack = DACK;
    end
  end

  initial begin
    tick(); tick();
    RESET = 1'b0;
    chk("rst_hrq", {31'd0, HRQ}, 32'd0);
    chk("rst_dack", {28'd0, DACK}, 32'd0);
    chk("rst_gv", {31'd0, grantValid}, 32'd0);
    chk("rst_gch", {30'd0, grantChannel}, 32'd0);
    chk("rst_order", {24'd0, priorityOrder}, 32'hE4);

    // Fixed priority, two requesters; HLDA two cycles after HRQ.
    DREQ = 4'b0110;
    tick();
    chk("hrq_lat", {31'd0, HRQ}, 32'd1);
    tick(); tick();
    chk("req_no_dack", {28'd0, DACK}, 32'd0);
    HLDA = 1'b1;
    push_grant(4'b0010, 2'd1);
    tick();
    chk("fix_dack", {28'd0, DACK}, 32'h2);
    chk("fix_gch", {30'd0, grantChannel}, 32'd1);
    DREQ = 4'b1000; maskReg = 4'b0010;
    tick();
    chk("hold_dack", {28'd0, DACK}, 32'h2);
    chk("hold_hrq", {31'd0, HRQ}, 32'd1);
    pulse_done();
    chk("fix_order", {24'd0, priorityOrder}, 32'hE4);
    HLDA = 1'b0; DREQ = 4'b0000; maskReg = 4'b0000;
    tick(); tick();

    // Rotating priority, all channels requesting, four transfers.
    priorityType = 1'b1;
    DREQ = 4'b1111; HLDA = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [3:0] ed;
      ed = 4'b0001 << t;
      push_grant(ed, t[1:0]);
      wait_grant();
      pulse_done();
      if (t == 0) chk("rot_order1", {24'd0, priorityOrder}, 32'h39);
    end
    chk("rot_order4", {24'd0, priorityOrder}, 32'hE4);
    DREQ = 4'b0000; HLDA = 1'b0;
    tick(); tick(); tick();

    // Masked request never raises HRQ; unmasking does after one cycle.
    priorityType = 1'b0;
    maskReg = 4'b0001; DREQ = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mask_hrq", {31'd0, HRQ}, 32'd0);
    end
    maskReg = 4'b0000;
    tick();
    chk("unmask_hrq", {31'd0, HRQ}, 32'd1);
    DREQ = 4'b0000;
    tick();
    chk("withdraw_hrq", {31'd0, HRQ}, 32'd0);
    tick();

    // HLDA arrives together with request withdrawal: release, no grant.
    DREQ = 4'b0010;
    tick();
    chk("late_hrq", {31'd0, HRQ}, 32'd1);
    DREQ = 4'b0000; HLDA = 1'b1;
    tick();
    chk("late_hrq0", {31'd0, HRQ}, 32'd0);
    chk("late_dack", {28'd0, DACK}, 32'd0);
    HLDA = 1'b0;
    tick(); tick();

    // Abort on HLDA drop outranks a simultaneous transferDone; no rotation.
    priorityType = 1'b1;
    DREQ = 4'b0100; HLDA = 1'b1;
    push_grant(4'b0100, 2'd2);
    wait_grant();
    HLDA = 1'b0; transferDone = 1'b1; DREQ = 4'b0000;
    tick();
    transferDone = 1'b0;
    chk("abort_dack", {28'd0, DACK}, 32'd0);
    chk("abort_hrq", {31'd0, HRQ}, 32'd0);
    chk("abort_order", {24'd0, priorityOrder}, 32'hE4);
    tick(); tick();

    // Reset during a grant after one rotation.
    DREQ = 4'b0001; HLDA = 1'b1;
    push_grant(4'b0001, 2'd0);
    wait_grant();
    pulse_done();
    chk("rst_rot_order", {24'd0, priorityOrder}, 32'h39);
    push_grant(4'b0001, 2'd0);
    wait_grant();
    RESET = 1'b1;
    tick();
    RESET = 1'b0; DREQ = 4'b0000; HLDA = 1'b0;
    chk("grst_dack", {28'd0, DACK}, 32'd0);
    chk("grst_hrq", {31'd0, HRQ}, 32'd0);
    chk("grst_gv", {31'd0, grantValid}, 32'd0);
    chk("grst_order", {24'd0, priorityOrder}, 32'hE4);
    tick(); tick();

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/dma_channel_arbiter.md
DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 DREQ  input  4  per-channel DMA request, active-high, bit n = channel n.
REQ-004 maskReg  input  4  per-channel mask; 1 = channel n ignored.
REQ-005 priorityType  input  1  0 = fixed priority, 1 = rotating priority.
REQ-006 HLDA  input  1  hold acknowledge from CPU, active-high.
REQ-007 transferDone  input  1  one-cycle pulse from timing/control marking end of the granted transfer.
REQ-008 HRQ  output  1  hold request to CPU, active-high, registered.
REQ-009 DACK  output  4  one-hot channel acknowledge, active-high, registered; 4'b0000 when no grant.
REQ-010 grantValid  output  1  1 while DACK is nonzero.
REQ-011 grantChannel  output  2  binary index of the granted channel; 2'b00 when grantValid = 0.
REQ-012 priorityOrder  output  8  four 2-bit channel IDs; [1:0] = highest priority, [7:6] = lowest.

Function
REQ-013 Effective request vector: effReq = DREQ & ~maskReg, evaluated each cycle.
REQ-014 FSM states: IDLE, REQ, GRANT, RELEASE; encoding is implementer's choice.
REQ-015 IDLE: if effReq != 0, go to REQ and assert HRQ on the next cycle. DREQ to HRQ latency is 1 cycle.
REQ-016 REQ: HRQ = 1. If HLDA = 1 and effReq != 0, pick the winner and go to GRANT; DACK is asserted the next cycle. HLDA to DACK latency is 1 cycle.
REQ-017 REQ: if effReq == 0 while HLDA = 0 (request withdrawn), go to IDLE and drop HRQ on the next cycle.
REQ-018 REQ: if HLDA = 1 and effReq == 0 in the same cycle, go to RELEASE; no DACK is issued.
REQ-019 Winner: the first channel in priorityOrder, scanning [1:0] then [3:2], [5:4], [7:6], whose effReq bit is 1.
REQ-020 GRANT: HRQ = 1 and DACK one-hot on the winner, held constant. DREQ and maskReg changes do not alter the current grant.
REQ-021 GRANT exit on transferDone = 1: on the next cycle DACK = 0 and HRQ = 0, and the FSM enters RELEASE.
REQ-022 GRANT abort on HLDA = 0 (takes precedence over a simultaneous transferDone):
- next cycle DACK = 0, HRQ = 0, state IDLE;
- priorityOrder unchanged.
REQ-023 RELEASE lasts exactly 1 cycle with HRQ = 0, then goes to IDLE. This guarantees at least one HRQ-low cycle between grants.
REQ-024 Rotation: on a completed transfer (REQ-021) with priorityType = 1, the served channel moves to [7:6]. The remaining three channels shift toward [1:0] with their relative order kept.
REQ-025 When priorityType = 0, priorityOrder is forced to 8'b11_10_01_00 on the next cycle and does not rotate.
REQ-026 priorityOrder always holds a permutation of {0,1,2,3}.

Reset
REQ-027 While RESET = 1 at a rising edge, the next state is:
- FSM = IDLE;
- HRQ = 0, DACK = 4'b0000;
- grantValid = 0, grantChannel = 2'b00;
- priorityOrder = 8'b11_10_01_00.
REQ-028 RESET during GRANT drops DACK and HRQ on the following cycle. No transferDone is required.
REQ-029 RESET has priority over all other inputs.

Configuration
REQ-030 Macro DMA_DREQ_SYNC_EN is defined: DREQ passes through a 2-flop synchronizer before forming effReq, and the DREQ to HRQ latency becomes 3 cycles.
REQ-031 Macro DMA_DREQ_SYNC_EN is undefined: DREQ is used directly, with latency per REQ-015. All other behaviour is identical.
REQ-032 Synchronizer flops reset to 0.

Verification
REQ-033 Fixed priority, DREQ = 4'b0110, mask = 0, HLDA raised 2 cycles after HRQ:
- DACK = 4'b0010 one cycle after HLDA;
- grantChannel = 2'b01.
REQ-034 Rotating priority, DREQ = 4'b1111 held, four full transfers:
- DACK sequence 0001, 0010, 0100, 1000;
- priorityOrder after the first transfer = 8'b00_11_10_01.
REQ-035 mask = 4'b0001, DREQ = 4'b0001 → HRQ stays 0 indefinitely. Then mask = 0 → HRQ = 1 one cycle later.
REQ-036 HLDA dropped during GRANT on channel 2 → next cycle DACK = 0 and HRQ = 0; priorityOrder unchanged.
REQ-037 RESET pulsed during GRANT with priorityType = 1 after one rotation:
- next cycle DACK = 0 and HRQ = 0;
- priorityOrder = 8'b11_10_01_00.
REQ-038 With DMA_DREQ_SYNC_EN defined, DREQ = 4'b1000 → HRQ = 1 exactly 3 cycles later, then DACK = 4'b1000 one cycle after HLDA.
